// File: rtl/jtag_master.sv
// jtag_master: JTAG TAP master. Runs one command at a time (DR scan, IR scan,
// TAP reset or Run-Test/Idle clocks) and returns the captured TDO bits.
// After reset it drives a TAP reset sequence before it accepts any command.
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while parked in RTI)
//   cmd_op                00 DR scan, 01 IR scan, 10 TAP reset, 11 RTI clocks
//   cmd_len               bit/clock count minus 1
//   cmd_data              TDI data, LSB shifted first
//   rsp_valid, rsp_data   one-cycle completion pulse, captured TDO (LSB first)
//   tck, tms, tdi, trst_n JTAG pins to the target
//   tdo                   JTAG data from the target (asynchronous)
module jtag_master #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [4:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        tck,
    output logic        tms,
    output logic        tdi,
    output logic        trst_n,
    input  logic        tdo
);

    typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, DONE} state_t;

    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_RTI = 2'b11;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic        tck_q, tck_d;
    logic        tms_q, tms_d;
    logic        tdi_q, tdi_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [4:0]  len_q, len_d;
    logic [31:0] data_q, data_d;
    logic [31:0] cap_q, cap_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        trst_n_q;
    logic        tdo_s1_q, tdo_s2_q;

    // TMS navigation patterns, LSB = first pulse.
    logic [7:0]  pre_pat;
    logic [5:0]  pre_last;
    logic        scan;
    logic [5:0]  cnt_inc;
    logic [5:0]  len6;

    always_comb begin
        if (state_q == INIT || op_q == OP_RST) begin
            pre_pat  = 8'b0001_1111;
            pre_last = 6'd5;
        end else if (op_q[0]) begin
            pre_pat  = 8'b0000_0011;
            pre_last = 6'd3;
        end else begin
            pre_pat  = 8'b0000_0001;
            pre_last = 6'd2;
        end
    end

    assign scan    = ~op_q[1];
    assign cnt_inc = cnt_q + 6'd1;
    assign len6    = {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= INIT;
            div_q      <= '0;
            tck_q      <= 1'b0;
            tms_q      <= 1'b1;
            tdi_q      <= 1'b0;
            cnt_q      <= '0;
            op_q       <= OP_RST;
            len_q      <= '0;
            data_q     <= '0;
            cap_q      <= '0;
            rsp_data_q <= '0;
            trst_n_q   <= 1'b0;
            tdo_s1_q   <= 1'b0;
            tdo_s2_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tck_q      <= tck_d;
            tms_q      <= tms_d;
            tdi_q      <= tdi_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            len_q      <= len_d;
            data_q     <= data_d;
            cap_q      <= cap_d;
            rsp_data_q <= rsp_data_d;
            trst_n_q   <= 1'b1;
            tdo_s1_q   <= tdo;
            tdo_s2_q   <= tdo_s1_q;
        end
    end

    // tms/tdi for the next pulse are loaded together with the falling tck
    // so they change only at the start of a low phase.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tck_d      = tck_q;
        tms_d      = tms_q;
        tdi_d      = tdi_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        len_d      = len_q;
        data_d     = data_q;
        cap_d      = cap_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    len_d  = cmd_len;
                    data_d = cmd_data;
                    cap_d  = '0;
                    cnt_d  = '0;
                    div_d  = '0;
                    tck_d  = 1'b0;
                    tdi_d  = 1'b0;
                    if (cmd_op == OP_RTI) begin
                        state_d = SHIFT;
                        tms_d   = 1'b0;
                    end else begin
                        state_d = PRE;
                        tms_d   = 1'b1;
                    end
                end
            end
            default: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d = '0;
                    if (!tck_q) begin
                        tck_d = 1'b1;
                        if (state_q == SHIFT && scan) begin
                            cap_d[cnt_q[4:0]] = tdo_s2_q;
                        end
                    end else begin
                        tck_d = 1'b0;
                        case (state_q)
                            INIT, PRE: begin
                                if (cnt_q == pre_last) begin
                                    if (state_q == INIT) begin
                                        state_d = IDLE;
                                        tms_d   = 1'b0;
                                    end else if (op_q == OP_RST) begin
                                        state_d = DONE;
                                        tms_d   = 1'b0;
                                    end else begin
                                        state_d = SHIFT;
                                        cnt_d   = '0;
                                        tms_d   = (len_q == 5'd0);
                                        tdi_d   = data_q[0];
                                    end
                                end else begin
                                    cnt_d = cnt_inc;
                                    tms_d = pre_pat[cnt_inc[2:0]];
                                end
                            end
                            SHIFT: begin
                                if (cnt_q == len6) begin
                                    tdi_d = 1'b0;
                                    cnt_d = '0;
                                    if (scan) begin
                                        state_d = POST;
                                        tms_d   = 1'b1;
                                    end else begin
                                        state_d = DONE;
                                        tms_d   = 1'b0;
                                    end
                                end else begin
                                    cnt_d = cnt_inc;
                                    tms_d = scan & (cnt_inc == len6);
                                    tdi_d = scan & data_q[cnt_inc[4:0]];
                                end
                            end
                            default: begin
                                tms_d = 1'b0;
                                if (cnt_q == 6'd1) begin
                                    state_d = DONE;
                                end else begin
                                    cnt_d = 6'd1;
                                end
                            end
                        endcase
                    end
                end
            end
        endcase

        if (state_d == DONE) begin
            rsp_data_d = cap_q;
        end
    end

    always_comb begin
        cmd_ready = (state_q == IDLE) || (state_q == DONE);
        rsp_valid = (state_q == DONE);
        rsp_data  = rsp_data_q;
        tck       = tck_q;
        tms       = tms_q;
        tdi       = tdi_q;
        trst_n    = trst_n_q;
    end

endmodule

// File: tb/tb_jtag_master.sv
module tb_jtag_master;

    localparam int unsigned CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [4:0]  cmd_len = 5'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        tck, tms, tdi, trst_n;
    logic        tdo;

    jtag_master #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .tck       (tck),
        .tms       (tms),
        .tdi       (tdi),
        .trst_n    (trst_n),
        .tdo       (tdo)
    );

    always #5 clk = ~clk;

    // Target model: 0 bypass register, 1 tied high, 2 loopback, 3 tied low.
    logic [1:0] tdo_mode = 2'd0;
    logic       byp_q = 1'b0;
    logic       byp_out = 1'b0;

    always @(posedge tck) byp_q <= tdi;
    always @(negedge tck) byp_out <= byp_q;

    always_comb begin
        case (tdo_mode)
            2'd0:    tdo = byp_out;
            2'd1:    tdo = 1'b1;
            2'd2:    tdo = tdi;
            default: tdo = 1'b0;
        endcase
    end

    // Pin monitor, sampled 1ns after each rising clk edge.
    int          cyc = 0;
    int          npulse = 0;
    int          rv_cnt = 0;
    int          rv_long = 0;
    int          idle_bad = 0;
    int          ph_n = 0;
    int          ph_bad = 0;
    int          run = 0;
    int          rise_at [0:127];
    logic [63:0] tms_vec = '0;
    logic [63:0] tdi_vec = '0;
    logic        tck_prev = 1'b0;
    logic        rv_prev = 1'b0;
    logic        low_ok = 1'b0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (tck !== tck_prev) begin
            if (tck === 1'b1) begin
                rise_at[npulse % 128] = cyc;
                npulse++;
                tms_vec = {tms_vec[62:0], tms};
                tdi_vec = {tdi_vec[62:0], tdi};
                if (low_ok) begin
                    ph_n++;
                    if (run != int'(CLK_DIV)) ph_bad++;
                end
                low_ok = 1'b0;
            end else if (rst !== 1'b1) begin
                ph_n++;
                if (run != int'(CLK_DIV)) ph_bad++;
                low_ok = (cmd_ready !== 1'b1);
            end else begin
                low_ok = 1'b0;
            end
            run = 1;
        end else begin
            run++;
        end
        tck_prev = tck;
        if (rsp_valid === 1'b1) begin
            rv_cnt++;
            if (rv_prev === 1'b1) rv_long++;
        end
        rv_prev = rsp_valid;
        if (cmd_ready === 1'b1 && (tck !== 1'b0 || tms !== 1'b0)) idle_bad++;
    end

    int nvec = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, cmd_ready, 1);
    endtask

    task automatic send(input string tag, input logic [1:0] op, input logic [4:0] len,
                        input logic [31:0] data, input bit drop);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        wait_ready(tag);
        @(negedge clk);
        if (drop) cmd_valid = 1'b0;
        check({tag, "_ready_fall"}, cmd_ready, 0);
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp);
        int n = 0;
        while (rsp_valid !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_tck"}, tck, 0);
        check({tag, "_rsp_ready"}, cmd_ready, 1);
        check({tag, "_rsp_data"}, rsp_data, exp);
    endtask

    int base, rv0, ph_n0, ph_bad0, cyc_rv, n;

    initial begin
        // Reset held for three clock edges.
        repeat (3) @(negedge clk);
        check("rst_tck", tck, 0);
        check("rst_tms", tms, 1);
        check("rst_tdi", tdi, 0);
        check("rst_trst_n", trst_n, 0);
        check("rst_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        base = npulse;
        rv0  = rv_cnt;
        rst  = 1'b0;
        @(negedge clk);
        check("init_trst_n", trst_n, 1);
        wait_ready("init");
        check("init_pulses", npulse - base, 6);
        check("init_tms", tms_vec[5:0], 6'b111110);
        check("init_no_rsp", rv_cnt - rv0, 0);

        // DR scan through a bypass register.
        tdo_mode = 2'd0;
        base = npulse;
        send("dr", 2'b00, 5'd7, 32'h0000_00A5, 1'b1);
        wait_rsp("dr", 32'h0000_004A);
        check("dr_pulses", npulse - base, 13);
        check("dr_tms", tms_vec[12:0], 13'b1000000000110);
        check("dr_tdi", tdi_vec[12:0], 13'b0001010010100);
        @(negedge clk);
        check("dr_rsp_pulse_end", rsp_valid, 0);
        check("dr_rsp_hold", rsp_data, 32'h0000_004A);

        // IR scan, tdo tied high.
        tdo_mode = 2'd1;
        base = npulse;
        send("ir", 2'b01, 5'd3, 32'h0000_000F, 1'b1);
        wait_rsp("ir", 32'h0000_000F);
        check("ir_pulses", npulse - base, 10);
        check("ir_tms", tms_vec[9:0], 10'b1100000110);
        check("ir_tdi", tdi_vec[9:0], 10'b0000111100);

        // Full-width DR scan with tdo looped back to tdi.
        tdo_mode = 2'd2;
        base    = npulse;
        ph_n0   = ph_n;
        ph_bad0 = ph_bad;
        send("full", 2'b00, 5'd31, 32'hDEAD_BEEF, 1'b1);
        wait_rsp("full", 32'hDEAD_BEEF);
        check("full_pulses", npulse - base, 37);
        check("full_tms", tms_vec[36:0], {3'b100, 31'b0, 3'b110});
        check("full_phases", ph_n - ph_n0, 73);
        check("full_phase_len", ph_bad - ph_bad0, 0);

        // Reset after the 10th rising edge of a 32-bit scan.
        base = npulse;
        send("mid", 2'b00, 5'd31, 32'h1234_5678, 1'b1);
        n = 0;
        while (npulse - base < 10 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("mid_10_edges", npulse - base, 10);
        check("mid_tck_high", tck, 1);
        rst = 1'b1;
        rv0 = rv_cnt;
        @(negedge clk);
        check("mid_tck", tck, 0);
        check("mid_tms", tms, 1);
        check("mid_tdi", tdi, 0);
        check("mid_trst_n", trst_n, 0);
        check("mid_ready", cmd_ready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_rsp_data", rsp_data, 0);
        rst  = 1'b0;
        base = npulse;
        wait_ready("reinit");
        check("reinit_pulses", npulse - base, 6);
        check("reinit_tms", tms_vec[5:0], 6'b111110);
        check("reinit_no_rsp", rv_cnt - rv0, 0);

        // Back-to-back: RTI clocks queued behind a short DR scan.
        tdo_mode = 2'd2;
        send("b2b1", 2'b00, 5'd3, 32'h0000_0005, 1'b0);
        cmd_op   = 2'b11;
        cmd_len  = 5'd3;
        cmd_data = 32'hFFFF_FFFF;
        wait_rsp("b2b1", 32'h0000_0005);
        cyc_rv = cyc;
        base   = npulse;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_accept", cmd_ready, 0);
        check("b2b_rsp_end", rsp_valid, 0);
        wait_rsp("b2b2", 32'h0000_0000);
        check("b2b_pulses", npulse - base, 4);
        check("b2b_tms", tms_vec[3:0], 4'b0000);
        check("b2b_tdi", tdi_vec[3:0], 4'b0000);
        check("b2b_first_rise", rise_at[base % 128] - cyc_rv, CLK_DIV + 1);

        @(negedge clk);
        check("idle_pins", idle_bad, 0);
        check("rsp_one_cycle", rv_long, 0);
        check("phase_len_all", ph_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
